writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Writeback stage of the pipeline: consumes the Memory stage's mem_wb_* outputs and commits them into a 32-entry, 32-bit architectural register file.
- Serves the Decode stage through two read ports with same-cycle write bypass.
- Provides a registered one-cycle-delayed copy of the committed write for Execute-stage forwarding.
- Counts retired register writes.

Parameters:
- DATA_WIDTH, 32, register and writeback value width
- COUNT_WIDTH, 32, width of the retired-write counter

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_wb_regdest  input  5  destination register index from Memory stage
- mem_wb_writereg  input  1  write enable from Memory stage
- mem_wb_wbvalue  input  DATA_WIDTH  value to commit
- id_rs_addr  input  5  Decode read port A index
- id_rt_addr  input  5  Decode read port B index
- wb_id_rsvalue  output  DATA_WIDTH  read port A data (combinational)
- wb_id_rtvalue  output  DATA_WIDTH  read port B data (combinational)
- wb_ex_regdest  output  5  registered destination of the last committed write
- wb_ex_writereg  output  1  registered valid for wb_ex_* forwarding
- wb_ex_wbvalue  output  DATA_WIDTH  registered value of the last committed write
- wb_retired_count  output  COUNT_WIDTH  number of committed writes since reset

Behaviour:
- Clock and reset: one clock, rising edge. Reset is synchronous, active-high, and sampled only on the clock edge.
- Commit condition: commit = mem_wb_writereg && (mem_wb_regdest != 0) && !reset.
- Register file write: on a rising edge with commit, regs[mem_wb_regdest] <= mem_wb_wbvalue. Latency 1 cycle; the array shows the new value from the following cycle.
- Register 0: hardwired zero and never written. A write to index 0 is a no-op: no array change, no forwarding valid, no count increment.
- Read ports (combinational, per port):
  - addr == 0 gives 0.
  - Otherwise, if commit and mem_wb_regdest == addr, give mem_wb_wbvalue (write-through bypass).
  - Otherwise give regs[addr].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Forwarding register, at each rising edge:
  - wb_ex_writereg <= commit.
  - wb_ex_regdest <= mem_wb_regdest and wb_ex_wbvalue <= mem_wb_wbvalue when commit; otherwise both hold their previous values.
- Retired counter: increments by 1 on each edge with commit. Wraps from all-ones to 0 with no flag.
- Reset edge: all 31 writable registers, wb_ex_regdest, wb_ex_writereg, wb_ex_wbvalue and wb_retired_count become 0.
- Write asserted on the reset edge: discarded; the array stays cleared and the counter stays 0.
- While reset is high: the bypass is disabled (commit is 0), so read ports return array contents. These are 0 after the first reset edge.
- Reset mid-stream: prior contents are lost. The first commit after reset deasserts is the first retired write (count 1).
- Back-to-back writes to the same register: the last write wins; each one counts.
- X-safety: mem_wb_regdest and mem_wb_wbvalue are don't-care when mem_wb_writereg = 0 and must not affect state.

Test Plan:
- Reset, then read all indices -> all 0; wb_ex_writereg = 0; wb_retired_count = 0.
- Commit regdest=5, value=0xDEADBEEF; next cycle id_rs_addr=5 -> wb_id_rsvalue = 0xDEADBEEF; wb_ex_regdest = 5; wb_ex_writereg = 1; wb_ex_wbvalue = 0xDEADBEEF; count = 1.
- Same-cycle bypass: commit regdest=7, value=0x12345678 with id_rs_addr=7 and id_rt_addr=7 -> both read ports show 0x12345678 in that same cycle, before the edge.
- Write regdest=0, value=0xFFFFFFFF -> next cycle read index 0 = 0; wb_ex_writereg = 0; count unchanged.
- Writes to reg 3 of 0x1 then 0x2 on consecutive cycles -> reg 3 reads 0x2; count +2; wb_ex_writereg stays 1 across both; then an idle cycle -> wb_ex_writereg = 0 and wb_ex_wbvalue holds 0x2.
- Write reg 9 = 0xAA; assert reset for one edge together with a write reg 9 = 0xBB -> reg 9 reads 0; count 0. With COUNT_WIDTH=4, 17 commits after reset -> count wraps to 1.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Bundles the Memory-to-Writeback commit bus, the Decode read ports and the
// Execute forwarding outputs of the writeback register file.
interface writeback_regfile_if #(
   parameter int DATA_WIDTH = 32
);
   logic [4:0]            mem_wb_regdest;
   logic                  mem_wb_writereg;
   logic [DATA_WIDTH-1:0] mem_wb_wbvalue;
   logic [4:0]            id_rs_addr;
   logic [4:0]            id_rt_addr;
   logic [DATA_WIDTH-1:0] wb_id_rsvalue;
   logic [DATA_WIDTH-1:0] wb_id_rtvalue;
   logic [4:0]            wb_ex_regdest;
   logic                  wb_ex_writereg;
   logic [DATA_WIDTH-1:0] wb_ex_wbvalue;

   modport master (
      output mem_wb_regdest,
      output mem_wb_writereg,
      output mem_wb_wbvalue,
      output id_rs_addr,
      output id_rt_addr,
      input  wb_id_rsvalue,
      input  wb_id_rtvalue,
      input  wb_ex_regdest,
      input  wb_ex_writereg,
      input  wb_ex_wbvalue
   );

   modport slave (
      input  mem_wb_regdest,
      input  mem_wb_writereg,
      input  mem_wb_wbvalue,
      input  id_rs_addr,
      input  id_rt_addr,
      output wb_id_rsvalue,
      output wb_id_rtvalue,
      output wb_ex_regdest,
      output wb_ex_writereg,
      output wb_ex_wbvalue
   );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: commits Memory-stage results into a 32x32 register file,
// serves two bypassed Decode read ports and a registered Execute forward.
module writeback_regfile #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   writeback_regfile_if.slave     bus,
   output logic [COUNT_WIDTH-1:0] wb_retired_count
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic                  commit_s;
   logic [DATA_WIDTH-1:0] regs_r [0:31];
   logic [DATA_WIDTH-1:0] rs_value_s;
   logic [DATA_WIDTH-1:0] rt_value_s;

   // Index 0 is excluded so regs_r[0] is never written and stays zero.
   always_comb begin
      commit_s = bus.mem_wb_writereg && (bus.mem_wb_regdest != 5'd0) && !reset;
   end

   // Read port A with write-through bypass of the committing value
   always_comb begin
      rs_value_s = {DATA_WIDTH{1'b0}};
      if (bus.id_rs_addr == 5'd0) begin
         rs_value_s = {DATA_WIDTH{1'b0}};
      end else if (commit_s && (bus.mem_wb_regdest == bus.id_rs_addr)) begin
         rs_value_s = bus.mem_wb_wbvalue;
      end else begin
         rs_value_s = regs_r[bus.id_rs_addr];
      end
   end

   // Read port B, independent of port A
   always_comb begin
      rt_value_s = {DATA_WIDTH{1'b0}};
      if (bus.id_rt_addr == 5'd0) begin
         rt_value_s = {DATA_WIDTH{1'b0}};
      end else if (commit_s && (bus.mem_wb_regdest == bus.id_rt_addr)) begin
         rt_value_s = bus.mem_wb_wbvalue;
      end else begin
         rt_value_s = regs_r[bus.id_rt_addr];
      end
   end

   assign bus.wb_id_rsvalue = rs_value_s;
   assign bus.wb_id_rtvalue = rt_value_s;

   // Array, forwarding register and retired counter share one reset/commit
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
         bus.wb_ex_regdest  <= 5'd0;
         bus.wb_ex_writereg <= 1'b0;
         bus.wb_ex_wbvalue  <= {DATA_WIDTH{1'b0}};
         wb_retired_count   <= {COUNT_WIDTH{1'b0}};
      end else begin
         bus.wb_ex_writereg <= commit_s;
         if (commit_s) begin
            regs_r[bus.mem_wb_regdest] <= bus.mem_wb_wbvalue;
            bus.wb_ex_regdest          <= bus.mem_wb_regdest;
            bus.wb_ex_wbvalue          <= bus.mem_wb_wbvalue;
            wb_retired_count           <= wb_retired_count + COUNT_ONE;
         end else begin
            bus.wb_ex_regdest <= bus.wb_ex_regdest;
            bus.wb_ex_wbvalue <= bus.wb_ex_wbvalue;
            wb_retired_count  <= wb_retired_count;
         end
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile, with a second instance
// using a 4-bit retired counter to exercise wrap-around.
module tb_writeback_regfile;

   logic        clock;
   logic        reset;
   logic [31:0] count_s;
   logic [3:0]  count4_s;
   int          checks;
   int          failures;

   writeback_regfile_if #(.DATA_WIDTH(32)) bus ();
   writeback_regfile_if #(.DATA_WIDTH(32)) bus4 ();

   assign bus4.mem_wb_regdest  = bus.mem_wb_regdest;
   assign bus4.mem_wb_writereg = bus.mem_wb_writereg;
   assign bus4.mem_wb_wbvalue  = bus.mem_wb_wbvalue;
   assign bus4.id_rs_addr      = bus.id_rs_addr;
   assign bus4.id_rt_addr      = bus.id_rt_addr;

   writeback_regfile #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
      .clock            (clock),
      .reset            (reset),
      .bus              (bus.slave),
      .wb_retired_count (count_s)
   );

   writeback_regfile #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
      .clock            (clock),
      .reset            (reset),
      .bus              (bus4.slave),
      .wb_retired_count (count4_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] val);
      bus.mem_wb_writereg = we;
      bus.mem_wb_regdest  = rd;
      bus.mem_wb_wbvalue  = val;
   endtask

   task automatic read(input logic [4:0] rs, input logic [4:0] rt);
      bus.id_rs_addr = rs;
      bus.id_rt_addr = rt;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      drive(1'b0, 5'd0, 32'd0);
      bus.id_rs_addr = 5'd0;
      bus.id_rt_addr = 5'd0;
      step();
      step();
      reset = 1'b0;

      // Cleared state after reset
      for (int i = 0; i < 32; i++) begin
         read(5'(i), 5'(31 - i));
         check("rst_rs", bus.wb_id_rsvalue, 32'd0);
         check("rst_rt", bus.wb_id_rtvalue, 32'd0);
      end
      check("rst_ex_we",  {31'd0, bus.wb_ex_writereg}, 32'd0);
      check("rst_ex_rd",  {27'd0, bus.wb_ex_regdest}, 32'd0);
      check("rst_ex_val", bus.wb_ex_wbvalue, 32'd0);
      check("rst_count",  count_s, 32'd0);
      check("rst_count4", {28'd0, count4_s}, 32'd0);

      // Basic commit, then junk on idle bus must not matter
      drive(1'b1, 5'd5, 32'hDEADBEEF);
      step();
      drive(1'b0, 5'd12, 32'hCAFE0000);
      read(5'd5, 5'd12);
      check("w5_rs",     bus.wb_id_rsvalue, 32'hDEADBEEF);
      check("w5_rt",     bus.wb_id_rtvalue, 32'd0);
      check("w5_ex_rd",  {27'd0, bus.wb_ex_regdest}, 32'd5);
      check("w5_ex_we",  {31'd0, bus.wb_ex_writereg}, 32'd1);
      check("w5_ex_val", bus.wb_ex_wbvalue, 32'hDEADBEEF);
      check("w5_count",  count_s, 32'd1);

      // Same-cycle bypass on both ports
      drive(1'b1, 5'd7, 32'h12345678);
      read(5'd7, 5'd7);
      check("byp_rs", bus.wb_id_rsvalue, 32'h12345678);
      check("byp_rt", bus.wb_id_rtvalue, 32'h12345678);
      step();
      drive(1'b0, 5'd7, 32'h0BAD0BAD);
      read(5'd7, 5'd5);
      check("w7_rs",    bus.wb_id_rsvalue, 32'h12345678);
      check("w7_rt",    bus.wb_id_rtvalue, 32'hDEADBEEF);
      check("w7_count", count_s, 32'd2);

      // Write to register 0 is a no-op
      drive(1'b1, 5'd0, 32'hFFFFFFFF);
      read(5'd0, 5'd0);
      check("r0_byp", bus.wb_id_rsvalue, 32'd0);
      step();
      drive(1'b0, 5'd9, 32'h55555555);
      read(5'd0, 5'd9);
      check("r0_rs",     bus.wb_id_rsvalue, 32'd0);
      check("r0_ex_we",  {31'd0, bus.wb_ex_writereg}, 32'd0);
      check("r0_ex_rd",  {27'd0, bus.wb_ex_regdest}, 32'd7);
      check("r0_ex_val", bus.wb_ex_wbvalue, 32'h12345678);
      check("r0_count",  count_s, 32'd2);
      step();
      check("junk_r9",    bus.wb_id_rtvalue, 32'd0);
      check("junk_count", count_s, 32'd2);

      // Back-to-back writes to register 3
      drive(1'b1, 5'd3, 32'h1);
      step();
      check("b2b_ex_we1", {31'd0, bus.wb_ex_writereg}, 32'd1);
      drive(1'b1, 5'd3, 32'h2);
      step();
      drive(1'b0, 5'd0, 32'd0);
      read(5'd3, 5'd3);
      check("b2b_ex_we2", {31'd0, bus.wb_ex_writereg}, 32'd1);
      check("b2b_rs",     bus.wb_id_rsvalue, 32'h2);
      check("b2b_count",  count_s, 32'd4);
      step();
      check("idle_ex_we",  {31'd0, bus.wb_ex_writereg}, 32'd0);
      check("idle_ex_val", bus.wb_ex_wbvalue, 32'h2);
      check("idle_ex_rd",  {27'd0, bus.wb_ex_regdest}, 32'd3);

      // Reset with a simultaneous write discards it
      drive(1'b1, 5'd9, 32'hAA);
      step();
      check("w9_count", count_s, 32'd5);
      reset = 1'b1;
      drive(1'b1, 5'd9, 32'hBB);
      read(5'd9, 5'd5);
      check("rst_nobyp_rs", bus.wb_id_rsvalue, 32'hAA);
      check("rst_nobyp_rt", bus.wb_id_rtvalue, 32'hDEADBEEF);
      step();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0);
      read(5'd9, 5'd5);
      check("mid_rst_r9",     bus.wb_id_rsvalue, 32'd0);
      check("mid_rst_r5",     bus.wb_id_rtvalue, 32'd0);
      check("mid_rst_count",  count_s, 32'd0);
      check("mid_rst_count4", {28'd0, count4_s}, 32'd0);
      check("mid_rst_ex_we",  {31'd0, bus.wb_ex_writereg}, 32'd0);
      check("mid_rst_ex_val", bus.wb_ex_wbvalue, 32'd0);

      // 17 commits: 4-bit counter wraps to 1
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 5'(k + 1), 32'h100 + 32'(k));
         step();
         if (k == 0) begin
            check("first_count", count_s, 32'd1);
         end
      end
      drive(1'b0, 5'd0, 32'd0);
      read(5'd17, 5'd1);
      check("wrap_count32", count_s, 32'd17);
      check("wrap_count4",  {28'd0, count4_s}, 32'd1);
      check("wrap_r17",     bus.wb_id_rsvalue, 32'h110);
      check("wrap_r1",      bus.wb_id_rtvalue, 32'h100);
      check("wrap4_r17",    bus4.wb_id_rsvalue, 32'h110);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
